// File: rtl/m68k_bus_master.sv
// 68000 asynchronous bus master: sequences S0..S7 half-states from a command port,
// with wait-state timeout, byte strobes, TAS read-modify-write and one BERR+HALT re-run.
module m68k_bus_master #(
    parameter int ADDR_WIDTH = 24,
    parameter int TIMEOUT    = 64,
    parameter int CNT_WIDTH  = 7
) (
    input  logic                  sysclk,
    input  logic                  sysrst,
    input  logic                  req,
    input  logic                  cmd_read,
    input  logic                  cmd_tas,
    input  logic [1:0]            cmd_be,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_fc,
    input  logic [15:0]           cmd_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            status,
    output logic [15:0]           rdata,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [2:0]            fc,
    output logic                  as_n,
    output logic                  uds_n,
    output logic                  lds_n,
    output logic                  w_n,
    output logic [15:0]           d_out,
    output logic                  d_oe,
    input  logic [15:0]           d_in,
    input  logic                  dtack_n,
    input  logic                  berr_n,
    input  logic                  halt_n
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7, ST_RWAIT
    } state_t;

    state_t                r_state, w_next;
    logic                  r_read, r_tas, r_wrph, r_retry, r_abort, r_done;
    logic [1:0]            r_be, r_res, r_status;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_fc;
    logic [15:0]           r_wdata, r_rdata;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic w_latch, w_restart, w_rwait, w_berr, w_tmo, w_inc, w_turn, w_fin, w_cap, w_wr;

    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_restart = 1'b0;
        w_rwait   = 1'b0;
        w_berr    = 1'b0;
        w_tmo     = 1'b0;
        w_inc     = 1'b0;
        w_turn    = 1'b0;
        w_fin     = 1'b0;
        w_wr      = !r_read || r_wrph;
        w_cap     = 1'b0;
        unique case (r_state)
            ST_IDLE: if (req) begin w_next = ST_S0; w_latch = 1'b1; end
            ST_S0:   w_next = ST_S1;
            ST_S1:   w_next = ST_S2;
            ST_S2:   w_next = ST_S3;
            ST_S3:   w_next = ST_S4;
            ST_S4: begin
                if (!berr_n) begin
                    if (!halt_n && !r_retry) begin w_next = ST_RWAIT; w_rwait = 1'b1; end
                    else begin w_next = ST_S7; w_berr = 1'b1; end
                end else if (!dtack_n) begin
                    w_next = ST_S5;
                end else if (r_cnt == CNT_WIDTH'(TIMEOUT)) begin
                    // timed-out cycle still runs S5/S6 (without capture) so abort
                    // completes at the same point a TIMEOUT-wait transfer would
                    w_next = ST_S5;
                    w_tmo  = 1'b1;
                end else begin
                    w_inc = 1'b1;
                end
            end
            ST_S5:   w_next = ST_S6;
            ST_S6: begin
                w_cap = !w_wr && !r_abort;
                if (r_tas && !r_wrph && !r_abort) begin w_next = ST_S2; w_turn = 1'b1; end
                else w_next = ST_S7;
            end
            ST_S7:   begin w_next = ST_IDLE; w_fin = 1'b1; end
            ST_RWAIT: if (halt_n) begin w_next = ST_S0; w_restart = 1'b1; end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state != ST_IDLE);
        done  = r_done;
        status = r_status;
        rdata = r_rdata;
        addr  = '0;
        fc    = '0;
        as_n  = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
        w_n   = 1'b1;
        d_oe  = 1'b0;
        d_out = '0;
        if (r_state inside {ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7}) begin
            addr = {r_addr[ADDR_WIDTH-1:1], 1'b0};
            fc   = r_fc;
        end
        if (r_state inside {ST_S2, ST_S3, ST_S4, ST_S5, ST_S6}) as_n = 1'b0;
        if ((!w_wr && (r_state inside {ST_S2, ST_S3, ST_S4, ST_S5, ST_S6})) ||
            ( w_wr && (r_state inside {ST_S4, ST_S5, ST_S6}))) begin
            uds_n = !r_be[1];
            lds_n = !r_be[0];
        end
        if (w_wr && (r_state inside {ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7})) w_n = 1'b0;
        if (w_wr && (r_state inside {ST_S3, ST_S4, ST_S5, ST_S6, ST_S7})) begin
            d_oe  = 1'b1;
            d_out = r_wrph ? (r_rdata | 16'h0080) : r_wdata;
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            r_state  <= ST_IDLE;
            r_read   <= 1'b0;
            r_tas    <= 1'b0;
            r_be     <= '0;
            r_addr   <= '0;
            r_fc     <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_cnt    <= '0;
            r_wrph   <= 1'b0;
            r_retry  <= 1'b0;
            r_abort  <= 1'b0;
            r_res    <= '0;
            r_status <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_fin;
            if (w_latch) begin
                r_read  <= cmd_read | cmd_tas;
                r_tas   <= cmd_tas;
                r_be    <= (cmd_be == 2'b00) ? 2'b11 : cmd_be;
                r_addr  <= cmd_addr;
                r_fc    <= cmd_fc;
                r_wdata <= cmd_wdata;
                r_retry <= 1'b0;
            end
            if (w_latch || w_restart) begin
                r_cnt   <= '0;
                r_wrph  <= 1'b0;
                r_abort <= 1'b0;
                r_res   <= 2'd0;
            end
            if (w_turn) begin
                r_cnt  <= '0;
                r_wrph <= 1'b1;
            end
            if (w_inc)   r_cnt   <= r_cnt + CNT_WIDTH'(1);
            if (w_rwait) r_retry <= 1'b1;
            if (w_berr)  r_res   <= 2'd1;
            if (w_tmo) begin
                r_res   <= 2'd2;
                r_abort <= 1'b1;
            end
            if (w_cap) begin
                if (r_be[1]) r_rdata[15:8] <= d_in[15:8];
                if (r_be[0]) r_rdata[7:0]  <= d_in[7:0];
            end
            if (w_fin) r_status <= (r_res == 2'd0 && r_retry) ? 2'd3 : r_res;
        end
    end
endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed bench for m68k_bus_master: per-cycle bus traces checked against
// hand-computed cycle numbers (cycle k = k clocks after req was sampled).
module tb_m68k_bus_master;
    logic        sysclk = 1'b0;
    logic        sysrst, req, cmd_read, cmd_tas;
    logic [1:0]  cmd_be;
    logic [23:0] cmd_addr;
    logic [2:0]  cmd_fc;
    logic [15:0] cmd_wdata, d_in;
    logic        busy, done, as_n, uds_n, lds_n, w_n, d_oe;
    logic [1:0]  status;
    logic [15:0] rdata, d_out;
    logic [23:0] addr;
    logic [2:0]  fc;
    logic        dtack_n, berr_n, halt_n;

    int tests = 0;
    int fails = 0;

    logic [127:0] as_l, uds_l, lds_l, wn_l, oe_l, busy_l;
    logic [15:0]  dout_l [0:127];
    logic [23:0]  addr_l [0:127];
    logic [2:0]   fc_l   [0:127];
    int done_at, done_cnt;

    m68k_bus_master #(.ADDR_WIDTH(24), .TIMEOUT(64), .CNT_WIDTH(7)) dut (
        .sysclk(sysclk), .sysrst(sysrst), .req(req), .cmd_read(cmd_read),
        .cmd_tas(cmd_tas), .cmd_be(cmd_be), .cmd_addr(cmd_addr), .cmd_fc(cmd_fc),
        .cmd_wdata(cmd_wdata), .busy(busy), .done(done), .status(status),
        .rdata(rdata), .addr(addr), .fc(fc), .as_n(as_n), .uds_n(uds_n),
        .lds_n(lds_n), .w_n(w_n), .d_out(d_out), .d_oe(d_oe), .d_in(d_in),
        .dtack_n(dtack_n), .berr_n(berr_n), .halt_n(halt_n)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic rd, input logic tas, input logic [1:0] be,
                       input logic [23:0] a, input logic [2:0] f, input logic [15:0] wd,
                       input logic [15:0] din, input logic [127:0] dt_m,
                       input logic [127:0] be_m, input logic [127:0] ha_m,
                       input int req_last, input int rst_at, input int limit);
        @(negedge sysclk);
        cmd_read = rd; cmd_tas = tas; cmd_be = be; cmd_addr = a; cmd_fc = f;
        cmd_wdata = wd; d_in = din; req = 1'b1;
        done_at = 0; done_cnt = 0;
        as_l = '1; uds_l = '1; lds_l = '1; wn_l = '1; oe_l = '0; busy_l = '0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge sysclk);
            as_l[c] = as_n; uds_l[c] = uds_n; lds_l[c] = lds_n; wn_l[c] = w_n;
            oe_l[c] = d_oe; busy_l[c] = busy;
            dout_l[c] = d_out; addr_l[c] = addr; fc_l[c] = fc;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
            req     = (c <= req_last);
            sysrst  = (rst_at != 0) && (c == rst_at);
            dtack_n = !dt_m[c];
            berr_n  = !be_m[c];
            halt_n  = !ha_m[c];
        end
        req = 1'b0; sysrst = 1'b0; dtack_n = 1'b1; berr_n = 1'b1; halt_n = 1'b1;
    endtask

    initial begin
        sysrst = 1'b1; req = 1'b0; cmd_read = 1'b0; cmd_tas = 1'b0; cmd_be = 2'b00;
        cmd_addr = '0; cmd_fc = '0; cmd_wdata = '0; d_in = '0;
        dtack_n = 1'b1; berr_n = 1'b1; halt_n = 1'b1;
        repeat (3) @(negedge sysclk);
        sysrst = 1'b0;
        @(negedge sysclk);
        chk("rst_strobes", {as_n, uds_n, lds_n, w_n, d_oe}, 5'b11110);
        chk("rst_busy_done", {busy, done, status}, 4'b0000);
        chk("rst_addr_fc", {addr, fc}, 27'd0);
        chk("rst_data", {rdata, d_out}, 32'd0);

        // zero-wait read
        run(1'b1, 1'b0, 2'b11, 24'h000004, 3'b110, 16'h0, 16'h1234,
            128'h20, '0, '0, 0, 0, 10);
        chk("rd_done_at", done_at, 9);
        chk("rd_done_cnt", done_cnt, 1);
        chk("rd_status", status, 0);
        chk("rd_rdata", rdata, 16'h1234);
        chk("rd_as_low", as_l[7:3], 5'b00000);
        chk("rd_as_edges", {as_l[2], as_l[8]}, 2'b11);
        chk("rd_addr_fc", {addr_l[2], fc_l[2]}, {24'h000004, 3'b110});
        chk("rd_wn_high", wn_l[10:1], 10'h3FF);
        chk("rd_ds_s2", {uds_l[3], lds_l[3]}, 2'b00);
        chk("rd_busy", {busy_l[1], busy_l[8], busy_l[9]}, 3'b110);

        // upper-byte write, 3 wait states
        run(1'b0, 1'b0, 2'b10, 24'h000012, 3'b101, 16'h12AB, 16'h0,
            128'h100, '0, '0, 0, 0, 13);
        chk("wr_done_at", done_at, 12);
        chk("wr_status", status, 0);
        chk("wr_lds_high", lds_l[12:1], 12'hFFF);
        chk("wr_uds", {uds_l[4], uds_l[5], uds_l[10], uds_l[11]}, 4'b1001);
        chk("wr_oe", {oe_l[3], oe_l[4], oe_l[11], oe_l[12]}, 4'b0110);
        chk("wr_dout", dout_l[4], 16'h12AB);
        chk("wr_wn", {wn_l[2], wn_l[3], wn_l[11], wn_l[12]}, 4'b1001);

        // no DTACK: timeout
        run(1'b1, 1'b0, 2'b11, 24'h000020, 3'b001, 16'h0, 16'hBEEF,
            '0, '0, '0, 0, 0, 75);
        chk("to_done_at", done_at, 73);
        chk("to_status", status, 2);
        chk("to_rdata_kept", rdata, 16'h1234);
        chk("to_as_tail", {as_l[71], as_l[72]}, 2'b01);

        // BERR+HALT, halt released after 5 cycles, re-run succeeds
        run(1'b1, 1'b0, 2'b11, 24'h000030, 3'b010, 16'h0, 16'h5A5A,
            128'h10000, 128'h20, 128'h7E0, 0, 0, 21);
        chk("rt_done_at", done_at, 20);
        chk("rt_status", status, 3);
        chk("rt_as", {as_l[6], as_l[10], as_l[14]}, 3'b110);
        chk("rt_rdata", rdata, 16'h5A5A);

        // second BERR after re-run
        run(1'b1, 1'b0, 2'b11, 24'h000030, 3'b010, 16'h0, 16'h7777,
            '0, 128'h10020, 128'h107E0, 0, 0, 19);
        chk("b2_done_at", done_at, 18);
        chk("b2_status", status, 1);
        chk("b2_rdata_kept", rdata, 16'h5A5A);

        // TAS
        run(1'b0, 1'b1, 2'b11, 24'h000100, 3'b101, 16'h0, 16'h0041,
            128'h420, '0, '0, 0, 0, 15);
        chk("tas_done_at", done_at, 14);
        chk("tas_status", status, 0);
        chk("tas_as_low", as_l[12:3], 10'h000);
        chk("tas_as_end", as_l[13], 1'b1);
        chk("tas_wdata", {oe_l[8], oe_l[9], dout_l[9]}, {2'b01, 16'h00C1});
        chk("tas_wn", {wn_l[7], wn_l[8], wn_l[13]}, 3'b100);
        chk("tas_ds", {uds_l[7], uds_l[8], uds_l[10], lds_l[9], lds_l[12]}, 5'b01010);
        chk("tas_rdata", rdata, 16'h0041);

        // reset during S4 of a write
        run(1'b0, 1'b0, 2'b11, 24'h000040, 3'b101, 16'h5555, 16'h0,
            '0, '0, '0, 0, 6, 12);
        chk("rs_busy", {busy_l[6], busy_l[7]}, 2'b10);
        chk("rs_strobes", {as_l[7], uds_l[7], lds_l[7], wn_l[7], oe_l[7]}, 5'b11110);
        chk("rs_no_done", done_cnt, 0);
        chk("rs_regs", {status, rdata}, 18'd0);

        // normal lower-byte write after reset
        run(1'b0, 1'b0, 2'b01, 24'h000042, 3'b101, 16'h00FF, 16'h0,
            128'h20, '0, '0, 0, 0, 10);
        chk("pw_done_at", done_at, 9);
        chk("pw_status", status, 0);
        chk("pw_ds", {uds_l[5], lds_l[5]}, 2'b10);

        // req held: ignored while busy, accepted in the done cycle
        run(1'b1, 1'b0, 2'b00, 24'h000051, 3'b110, 16'h0, 16'h2222,
            128'h4020, '0, '0, 9, 0, 20);
        chk("bb_done_at", done_at, 9);
        chk("bb_done_cnt", done_cnt, 2);
        chk("bb_busy", {busy_l[8], busy_l[9], busy_l[10]}, 3'b101);
        chk("bb_addr_bit0", addr_l[12], 24'h000050);
        chk("bb_rdata", rdata, 16'h2222);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
